pe_feeder: RTL and testbench

Initiator-side driver for one processing element (PE) in the PE array. It runs one PE job from a single `start` pulse:
- configures the PE;
- streams filter, ifmap and ipsum words out of the local buffer over valid/ready channels;
- collects the PE's opsum words and writes them back to the buffer.

It sits between the global buffer read/write ports and a single PE.

---
 rtl/pe_feeder_pkg.sv | 31 +++
 rtl/rd_stream_src.sv | 53 +++++
 rtl/pe_feeder.sv | 212 +++++++++++++++++++++
 tb/tb_pe_feeder.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_feeder_pkg.sv
// rtl/pe_feeder_pkg.sv - shared types and constants for the PE feeder
package pe_feeder_pkg;

    localparam int DATA_BITS_DEF   = 32;
    localparam int ADDR_W_DEF      = 10;
    localparam int CONFIG_SIZE_DEF = 9;

    // i_config packing: {p[1:0], F[4:0], q[1:0]}
    localparam int P_MSB = 8;
    localparam int P_LSB = 7;
    localparam int F_MSB = 6;
    localparam int F_LSB = 2;
    localparam int Q_MSB = 1;
    localparam int Q_LSB = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONFIG,
        S_FILTER,
        S_IFMAP,
        S_IPSUM,
        S_OPSUM,
        S_DONE
    } state_t;

    // Phases that pull words out of the buffer through the shared stream source.
    function automatic logic is_stream(input state_t s);
        return (s == S_FILTER) || (s == S_IFMAP) || (s == S_IPSUM);
    endfunction

endpackage

// File: rtl/rd_stream_src.sv
// rtl/rd_stream_src.sv - buffer-read stream source with one-word holding register
//
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   more          current phase still has words to read
//   prefetch      force the first read of the next phase
//   ready         consumer ready of the active channel
//   rd_data       buffer data, valid one cycle after rd_issue
//   rd_issue      read request to the buffer
//   valid, data   stream word presented to the active channel
//   fire          handshake this cycle
module rd_stream_src #(
    parameter int DATA_BITS = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 more,
    input  logic                 prefetch,
    input  logic                 ready,
    input  logic [DATA_BITS-1:0] rd_data,
    output logic                 rd_issue,
    output logic                 valid,
    output logic [DATA_BITS-1:0] data,
    output logic                 fire
);

    logic                 valid_q;
    logic                 fresh_q;   // rd_data on the bus belongs to the word being presented
    logic [DATA_BITS-1:0] hold_q;

    assign fire     = valid_q & ready;
    // Refill only when the slot is empty or drains this cycle: at most one word in flight.
    assign rd_issue = prefetch | (more & (~valid_q | fire));
    assign valid    = valid_q;
    // The buffer word is used straight off the bus on arrival and kept in hold_q
    // afterwards, so a stalled word survives whatever the buffer drives later.
    assign data     = fresh_q ? rd_data : hold_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            fresh_q <= 1'b0;
            hold_q  <= '0;
        end else begin
            valid_q <= rd_issue | (valid_q & ~fire);
            fresh_q <= rd_issue;
            if (fresh_q) begin
                hold_q <= rd_data;
            end
        end
    end

endmodule

// File: rtl/pe_feeder.sv
// rtl/pe_feeder.sv - runs one PE job: config, filter/ifmap/ipsum streams, opsum write-back
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   start, cfg_*, *_base     job launch and parameters (sampled in IDLE)
//   busy, done               job status
//   PE_en, i_config          PE configuration strobe and word
//   filter/ifmap/ipsum(_valid/_ready)  outgoing streams to the PE
//   opsum(_valid/_ready)     incoming partial sums from the PE
//   rd_*, wr_*               global buffer read and write ports
module pe_feeder
    import pe_feeder_pkg::*;
#(
    parameter int DATA_BITS   = DATA_BITS_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int CONFIG_SIZE = CONFIG_SIZE_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [1:0]             cfg_p,
    input  logic [4:0]             cfg_F,
    input  logic [1:0]             cfg_q,
    input  logic [ADDR_W-1:0]      filter_base,
    input  logic [ADDR_W-1:0]      ifmap_base,
    input  logic [ADDR_W-1:0]      ipsum_base,
    input  logic [ADDR_W-1:0]      opsum_base,
    output logic                   busy,
    output logic                   done,
    output logic                   PE_en,
    output logic [CONFIG_SIZE-1:0] i_config,
    output logic [DATA_BITS-1:0]   filter,
    output logic [DATA_BITS-1:0]   ifmap,
    output logic [DATA_BITS-1:0]   ipsum,
    output logic                   filter_valid,
    output logic                   ifmap_valid,
    output logic                   ipsum_valid,
    input  logic                   filter_ready,
    input  logic                   ifmap_ready,
    input  logic                   ipsum_ready,
    input  logic [DATA_BITS-1:0]   opsum,
    input  logic                   opsum_valid,
    output logic                   opsum_ready,
    output logic                   rd_en,
    output logic [ADDR_W-1:0]      rd_addr,
    input  logic [DATA_BITS-1:0]   rd_data,
    output logic                   wr_en,
    output logic [ADDR_W-1:0]      wr_addr,
    output logic [DATA_BITS-1:0]   wr_data
);

    state_t              state, state_next, phase;
    logic [1:0]          p_q, q_q;
    logic [4:0]          fcfg_q;
    logic [4:0]          f_q;
    logic [ADDR_W-1:0]   fb_q, ib_q, pb_q, ob_q;
    logic [ADDR_W-1:0]   f_off_q;   // f*(p+1), built by accumulation
    logic [ADDR_W-1:0]   k_q;       // ifmap words read so far this job
    logic [3:0]          iss_cnt;   // reads issued in the current phase
    logic [3:0]          hs_cnt;    // handshakes/writes done in the current phase
    logic [3:0]          p1, len, idx;
    logic                ready_sel, src_valid, src_fire, rd_issue;
    logic                more, prefetch, evt, last, accept;
    logic [DATA_BITS-1:0] src_data;
    logic [ADDR_W-1:0]   rd_addr_c;
    logic [CONFIG_SIZE-1:0] cfg_word;

    assign accept = (state == S_IDLE) && start;
    assign p1     = {2'b00, p_q} + 4'd1;

    always_comb begin
        len = 4'd0;
        case (state)
            S_FILTER: len = p1 + p1 + p1;
            S_IFMAP:  len = (f_q == 5'd0) ? 4'd3 : 4'd1;
            S_IPSUM:  len = p1;
            S_OPSUM:  len = p1;
            default:  len = 4'd0;
        endcase
    end

    always_comb begin
        ready_sel = 1'b0;
        case (state)
            S_FILTER: ready_sel = filter_ready;
            S_IFMAP:  ready_sel = ifmap_ready;
            S_IPSUM:  ready_sel = ipsum_ready;
            default:  ready_sel = 1'b0;
        endcase
    end

    assign wr_en = (state == S_OPSUM) && opsum_valid;
    assign evt   = src_fire | wr_en;
    assign last  = evt && (hs_cnt == len - 4'd1);

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (start) state_next = S_CONFIG;
            S_CONFIG: state_next = S_FILTER;
            S_FILTER: if (last) state_next = S_IFMAP;
            S_IFMAP:  if (last) state_next = S_IPSUM;
            S_IPSUM:  if (last) state_next = S_OPSUM;
            S_OPSUM:  if (last) state_next = (f_q == fcfg_q) ? S_DONE : S_IFMAP;
            S_DONE:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // The first read of a stream phase goes out in the cycle the previous phase ends.
    assign prefetch = (state_next != state) && is_stream(state_next);
    assign more     = is_stream(state) && (iss_cnt < len);
    assign phase    = prefetch ? state_next : state;
    assign idx      = prefetch ? 4'd0 : iss_cnt;

    always_comb begin
        rd_addr_c = '0;
        case (phase)
            S_FILTER: rd_addr_c = fb_q + ADDR_W'(idx);
            S_IFMAP:  rd_addr_c = ib_q + k_q;
            S_IPSUM:  rd_addr_c = pb_q + f_off_q + ADDR_W'(idx);
            default:  rd_addr_c = '0;
        endcase
    end

    rd_stream_src #(.DATA_BITS(DATA_BITS)) u_src (
        .clk      (clk),
        .rst      (rst),
        .more     (more),
        .prefetch (prefetch),
        .ready    (ready_sel),
        .rd_data  (rd_data),
        .rd_issue (rd_issue),
        .valid    (src_valid),
        .data     (src_data),
        .fire     (src_fire)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            p_q     <= '0;
            q_q     <= '0;
            fcfg_q  <= '0;
            f_q     <= '0;
            fb_q    <= '0;
            ib_q    <= '0;
            pb_q    <= '0;
            ob_q    <= '0;
            f_off_q <= '0;
            k_q     <= '0;
            iss_cnt <= '0;
            hs_cnt  <= '0;
        end else begin
            state <= state_next;
            if (state_next != state) begin
                iss_cnt <= prefetch ? 4'd1 : 4'd0;
                hs_cnt  <= 4'd0;
            end else begin
                iss_cnt <= iss_cnt + {3'b000, rd_issue};
                hs_cnt  <= hs_cnt + {3'b000, evt};
            end
            if (accept) begin
                p_q     <= cfg_p;
                fcfg_q  <= cfg_F;
                q_q     <= cfg_q;
                fb_q    <= filter_base;
                ib_q    <= ifmap_base;
                pb_q    <= ipsum_base;
                ob_q    <= opsum_base;
                f_q     <= '0;
                f_off_q <= '0;
                k_q     <= '0;
            end else begin
                if (rd_issue && (phase == S_IFMAP)) begin
                    k_q <= k_q + 1'b1;
                end
                if ((state == S_OPSUM) && last && (f_q != fcfg_q)) begin
                    f_q     <= f_q + 5'd1;
                    f_off_q <= f_off_q + ADDR_W'(p1);
                end
            end
        end
    end

    always_comb begin
        cfg_word              = '0;
        cfg_word[P_MSB:P_LSB] = p_q;
        cfg_word[F_MSB:F_LSB] = fcfg_q;
        cfg_word[Q_MSB:Q_LSB] = q_q;
    end

    assign busy         = (state == S_IDLE) ? start : (state != S_DONE);
    assign done         = (state == S_DONE);
    assign PE_en        = (state == S_CONFIG);
    assign i_config     = (state == S_CONFIG) ? cfg_word : '0;

    assign filter_valid = (state == S_FILTER) && src_valid;
    assign ifmap_valid  = (state == S_IFMAP)  && src_valid;
    assign ipsum_valid  = (state == S_IPSUM)  && src_valid;
    assign filter       = (state == S_FILTER) ? src_data : '0;
    assign ifmap        = (state == S_IFMAP)  ? src_data : '0;
    assign ipsum        = (state == S_IPSUM)  ? src_data : '0;

    assign rd_en        = rd_issue;
    assign rd_addr      = rd_issue ? rd_addr_c : '0;

    assign opsum_ready  = (state == S_OPSUM);
    assign wr_addr      = wr_en ? (ob_q + f_off_q + ADDR_W'(hs_cnt)) : '0;
    assign wr_data      = wr_en ? opsum : '0;

endmodule

// File: tb/tb_pe_feeder.sv
// tb/tb_pe_feeder.sv - self-checking bench for pe_feeder
module tb_pe_feeder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  cfg_p = '0, cfg_q = '0;
    logic [4:0]  cfg_F = '0;
    logic [9:0]  filter_base = '0, ifmap_base = '0, ipsum_base = '0, opsum_base = '0;
    logic        busy, done, PE_en;
    logic [8:0]  i_config;
    logic [31:0] filter, ifmap, ipsum;
    logic        filter_valid, ifmap_valid, ipsum_valid;
    logic        filter_ready = 1'b0, ifmap_ready = 1'b0, ipsum_ready = 1'b0;
    logic [31:0] opsum = '0;
    logic        opsum_valid = 1'b0, opsum_ready;
    logic        rd_en, wr_en;
    logic [9:0]  rd_addr, wr_addr;
    logic [31:0] rd_data = '0, wr_data;

    always #5 clk = ~clk;

    pe_feeder dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_p(cfg_p), .cfg_F(cfg_F), .cfg_q(cfg_q),
        .filter_base(filter_base), .ifmap_base(ifmap_base),
        .ipsum_base(ipsum_base), .opsum_base(opsum_base),
        .busy(busy), .done(done), .PE_en(PE_en), .i_config(i_config),
        .filter(filter), .ifmap(ifmap), .ipsum(ipsum),
        .filter_valid(filter_valid), .ifmap_valid(ifmap_valid), .ipsum_valid(ipsum_valid),
        .filter_ready(filter_ready), .ifmap_ready(ifmap_ready), .ipsum_ready(ipsum_ready),
        .opsum(opsum), .opsum_valid(opsum_valid), .opsum_ready(opsum_ready),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    // Expected traffic, built from the job parameters alone.
    logic [9:0]  exp_rd[$], exp_f[$], exp_i[$], exp_p[$], exp_wa[$];
    logic [9:0]  rd_log[$], if_log[$];
    int          op_pend = 0, op_seq = 0, done_cnt = 0, mode = 0;
    logic        done_seen = 1'b0;
    logic        pend_rd = 1'b0;
    logic [9:0]  pend_addr = '0;
    logic        st_f = 1'b0, st_i = 1'b0, st_p = 1'b0;
    logic [31:0] d_f = '0, d_i = '0, d_p = '0;
    int          t_start = 0, fv_first = -1, fv_cnt = 0, f_last_hs = -1;

    function automatic logic [31:0] memval(input logic [9:0] a);
        return {6'h2A, a, 6'h15, a};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic plan(input int p, input int F, input logic [9:0] fb, input logic [9:0] ib,
                        input logic [9:0] pb, input logic [9:0] ob);
        logic [9:0] a;
        int k = 0;
        for (int i = 0; i < 3 * (p + 1); i++) begin
            a = 10'(fb + 10'(i)); exp_rd.push_back(a); exp_f.push_back(a);
        end
        for (int f = 0; f <= F; f++) begin
            for (int j = 0; j < ((f == 0) ? 3 : 1); j++) begin
                a = 10'(ib + 10'(k)); k++; exp_rd.push_back(a); exp_i.push_back(a);
            end
            for (int i = 0; i <= p; i++) begin
                a = 10'(pb + 10'(f * (p + 1) + i)); exp_rd.push_back(a); exp_p.push_back(a);
                exp_wa.push_back(10'(ob + 10'(f * (p + 1) + i)));
            end
        end
    endtask

    task automatic clear_model();
        exp_rd.delete(); exp_f.delete(); exp_i.delete(); exp_p.delete(); exp_wa.delete();
        op_pend = 0; pend_rd = 1'b0; st_f = 1'b0; st_i = 1'b0; st_p = 1'b0;
        opsum_valid = 1'b0; opsum = '0;
    endtask

    task automatic check_zero(input string nm);
        check({nm, "_ctl"}, {23'd0, PE_en, busy, done, rd_en, wr_en, opsum_ready,
                             filter_valid, ifmap_valid, ipsum_valid}, 32'd0);
        check({nm, "_data"}, filter | ifmap | ipsum | wr_data, 32'd0);
        check({nm, "_addr"}, {3'd0, rd_addr, wr_addr, i_config}, 32'd0);
    endtask

    task automatic check_stream(input string nm, input logic [31:0] d, input logic [9:0] q[$]);
        if (q.size() == 0) check({nm, "_extra"}, 32'd1, 32'd0);
        else check({nm, "_data"}, d, memval(q[0]));
    endtask

    // PE model and per-cycle compare: inputs change at the falling edge, outputs
    // are compared 1 time unit later while they are stable for the coming rising edge.
    initial forever begin
        @(negedge clk);
        filter_ready = (mode == 1) ? ~filter_ready : (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
        ifmap_ready  = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
        ipsum_ready  = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
        if (op_pend > 0 && (mode != 2 || $urandom_range(0, 2) != 0)) begin
            opsum_valid = 1'b1; opsum = 32'hC0DE_0000 + 32'(op_seq);
        end else begin
            opsum_valid = 1'b0; opsum = '0;
        end
        #1;
        if (rst) begin
            check("valid_onehot", {31'd0, (32'(filter_valid) + 32'(ifmap_valid) + 32'(ipsum_valid)) <= 1}, 32'd1);
            if (st_f) begin check("filter_hold_v", filter_valid, 1); check("filter_hold_d", filter, d_f); end
            if (st_i) begin check("ifmap_hold_v", ifmap_valid, 1);  check("ifmap_hold_d", ifmap, d_i); end
            if (st_p) begin check("ipsum_hold_v", ipsum_valid, 1);  check("ipsum_hold_d", ipsum, d_p); end
            pend_rd = rd_en; pend_addr = rd_addr;
            if (rd_en) begin
                rd_log.push_back(rd_addr);
                if (exp_rd.size() == 0) check("rd_extra", 32'd1, 32'd0);
                else check("rd_addr", rd_addr, exp_rd.pop_front());
            end
            if (filter_valid) begin
                fv_cnt++;
                if (fv_first < 0) fv_first = cyc;
            end
            if (filter_valid && filter_ready) begin
                f_last_hs = cyc;
                check_stream("filter", filter, exp_f);
                if (exp_f.size() > 0) void'(exp_f.pop_front());
            end
            if (ifmap_valid && ifmap_ready) begin
                if_log.push_back(ifmap[9:0]);
                check_stream("ifmap", ifmap, exp_i);
                if (exp_i.size() > 0) void'(exp_i.pop_front());
            end
            if (ipsum_valid && ipsum_ready) begin
                check_stream("ipsum", ipsum, exp_p);
                if (exp_p.size() > 0) void'(exp_p.pop_front());
                op_pend++;
            end
            if (opsum_valid && opsum_ready) begin
                check("wr_en", wr_en, 1);
                check("wr_data", wr_data, opsum);
                if (exp_wa.size() == 0) check("wr_extra", 32'd1, 32'd0);
                else check("wr_addr", wr_addr, exp_wa.pop_front());
                op_seq++; op_pend--;
            end else if (wr_en) begin
                check("wr_spurious", wr_en, 0);
            end
            if (done) begin
                done_cnt++; done_seen = 1'b1;
                check("busy_at_done", busy, 0);
            end
            st_f = filter_valid && !filter_ready; d_f = filter;
            st_i = ifmap_valid && !ifmap_ready;   d_i = ifmap;
            st_p = ipsum_valid && !ipsum_ready;   d_p = ipsum;
        end
    end

    // Buffer model: data one cycle after the read, junk when nothing was read.
    initial forever begin
        @(posedge clk);
        #1;
        rd_data = pend_rd ? memval(pend_addr) : $urandom;
    end

    task automatic start_job(input int p, input int F, input int q, input logic [9:0] fb,
                             input logic [9:0] ib, input logic [9:0] pb, input logic [9:0] ob,
                             input int md);
        mode = md;
        plan(p, F, fb, ib, pb, ob);
        rd_log.delete(); if_log.delete();
        done_cnt = 0; done_seen = 1'b0; fv_first = -1; fv_cnt = 0; f_last_hs = -1;
        @(negedge clk);
        cfg_p = 2'(p); cfg_F = 5'(F); cfg_q = 2'(q);
        filter_base = fb; ifmap_base = ib; ipsum_base = pb; opsum_base = ob;
        start = 1'b1; t_start = cyc;
        @(negedge clk);
        start = 1'b0;
        #1;
        check("cfg_pe_en", PE_en, 1);
        check("cfg_busy", busy, 1);
        check("cfg_rd_en", rd_en, 1);
        check("cfg_word", i_config, {2'(p), 5'(F), 2'(q)});
    endtask

    task automatic finish_job(input logic inj);
        int n = 0;
        logic inj_done = 1'b0;
        while (!done_seen && n < 3000) begin
            @(negedge clk);
            n++;
            if (inj && !inj_done && ipsum_valid) begin
                start = 1'b1; cfg_p = 2'd0; cfg_F = 5'd0;
                filter_base = 10'h3C0; ifmap_base = 10'h3C0; inj_done = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        if (!done_seen) check("job_timeout", 32'd1, 32'd0);
        if (inj) check("inj_seen", inj_done, 1);
        repeat (4) @(negedge clk);
        check("rd_left", exp_rd.size(), 0);
        check("wr_left", exp_wa.size(), 0);
        check("done_pulses", done_cnt, 1);
        check("idle_busy", busy, 0);
    endtask

    initial begin
        logic [9:0] lit1 [7];
        logic [9:0] litw [4];
        lit1 = '{10'h010, 10'h011, 10'h012, 10'h020, 10'h021, 10'h022, 10'h030};
        litw = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
        #2;
        check_zero("reset");
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // Minimal job
        start_job(0, 0, 0, 10'h10, 10'h20, 10'h30, 10'h40, 0);
        finish_job(1'b0);
        check("min_rd_count", rd_log.size(), 7);
        for (int i = 0; i < 7 && i < rd_log.size(); i++) check("min_rd_lit", rd_log[i], lit1[i]);

        // Filter back-pressure
        start_job(0, 0, 1, 10'h50, 10'h60, 10'h70, 10'h80, 1);
        finish_job(1'b0);

        // Maximum config, random readies, start injected during IPSUM
        start_job(3, 2, 3, 10'h100, 10'h140, 10'h180, 10'h1C0, 2);
        finish_job(1'b1);
        check("max_ifmap_count", if_log.size(), 5);

        // Throughput
        start_job(3, 0, 0, 10'h200, 10'h220, 10'h240, 10'h260, 0);
        finish_job(1'b0);
        check("tp_first_valid", fv_first, t_start + 2);
        check("tp_last_hs", f_last_hs, t_start + 13);
        check("tp_filter_cycles", fv_cnt, 12);

        // Asynchronous reset during FILTER, then a clean job
        start_job(1, 1, 0, 10'h300, 10'h320, 10'h340, 10'h360, 0);
        begin
            int n = 0;
            while (!filter_valid && n < 20) begin @(negedge clk); #1; n++; end
            check("pre_reset_filter", filter_valid, 1);
        end
        @(negedge clk);
        #3 rst = 1'b0;
        #1 check_zero("mid_reset");
        clear_model();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        start_job(1, 1, 0, 10'h300, 10'h320, 10'h340, 10'h360, 2);
        finish_job(1'b0);

        // ifmap address wrap
        start_job(0, 1, 0, 10'h10, 10'h3FE, 10'h30, 10'h40, 0);
        finish_job(1'b0);
        check("wrap_count", if_log.size(), 4);
        for (int i = 0; i < 4 && i < if_log.size(); i++) check("wrap_lit", if_log[i], litw[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
